// File: rtl/sum_accumulator_pkg.sv
// sum_accumulator_pkg: shared state encoding, default parameters and seven-segment codes.
package sum_accumulator_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FULL = 2'd2} state_t;
  localparam int ACC_W_DEF = 8;
  localparam int MAX_SAMPLES_DEF = 15;
  localparam int CNT_W_DEF = 4;
  localparam int REFRESH_DIV_DEF = 1024;
  // Active-high segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/sum_accumulator_hex7seg.sv
// hex7seg: combinational 4-bit to seven-segment decoder.
module hex7seg
  import sum_accumulator_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_CODE[nib];
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: handshaked accumulator of adder results with sample budget and muxed hex display.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int MAX_SAMPLES = MAX_SAMPLES_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic [6:0]       seg,
  output logic             dig_sel
);
  localparam int RW = $clog2(REFRESH_DIV);
  state_t state;
  logic [RW-1:0] refresh;
  logic [ACC_W:0] total;
  logic last;
  logic [3:0] nib;
  logic [6:0] seg_next;
  assign sum_ready = state != FULL;
  assign total = {1'b0, acc_out} + (ACC_W + 1)'(sum_in);
  assign last = count == CNT_W'(MAX_SAMPLES - 1);
  assign nib = dig_sel ? acc_out[7:4] : acc_out[3:0];
  hex7seg u_hex (.nib(nib), .seg(seg_next));
  // clear outranks a same-edge transfer, so the offered sample is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      state <= IDLE;
      acc_out <= '0;
      ovf <= 1'b0;
      count <= '0;
      done <= 1'b0;
    end else if (sum_valid && sum_ready) begin
      acc_out <= total[ACC_W-1:0];
      ovf <= ovf | total[ACC_W];
      count <= count + 1'b1;
      state <= last ? FULL : ACCUM;
      done <= last;
    end
  end
  // Display keeps running through clear; only rst restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh <= '0;
      dig_sel <= 1'b0;
      seg <= SEG_CODE[0];
    end else begin
      refresh <= refresh + 1'b1;
      if (&refresh) dig_sel <= ~dig_sel;
      seg <= seg_next;
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed checks of accumulation, overflow, saturation, clear and display mux.
module tb_sum_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] sum_in = '0;
  logic sum_valid = 1'b0;
  logic sum_ready;
  logic clear = 1'b0;
  logic [7:0] acc_out;
  logic ovf;
  logic [3:0] count;
  logic done;
  logic [6:0] seg;
  logic dig_sel;
  int checks = 0;
  int failures = 0;
  int edges = 0;
  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  sum_accumulator #(.ACC_W(8), .MAX_SAMPLES(15), .CNT_W(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .clear(clear), .acc_out(acc_out), .ovf(ovf), .count(count), .done(done),
    .seg(seg), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) edges <= 0;
    else edges <= edges + 1;

  function automatic logic dig_at(input int e);
    return ((e / 4) % 2) == 1;
  endfunction

  function automatic logic [6:0] seg_model(input logic [7:0] acc, input int e);
    logic [3:0] n;
    n = dig_at(e - 1) ? acc[7:4] : acc[3:0];
    return hex_tab[n];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] v);
    sum_in = v;
    sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    // Asynchronous reset mid-cycle, checked before any edge
    #2 rst = 1'b1;
    #1;
    chk("rst_acc", acc_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", sum_ready, 1);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_dig", dig_sel, 0);
    sum_in = 5'd5;
    sum_valid = 1'b1;
    tick();
    chk("rst_ignore_xfer", acc_out, 0);
    sum_valid = 1'b0;
    rst = 1'b0;
    // Three single-cycle transfers
    send(5'h05);
    chk("acc_1", acc_out, 5);
    send(5'h1E);
    chk("acc_2", acc_out, 35);
    send(5'h0F);
    chk("acc_3", acc_out, 8'h32);
    chk("acc_count", count, 3);
    chk("acc_ovf", ovf, 0);
    tick();
    chk("acc_dig", dig_sel, dig_at(edges));
    chk("acc_seg", seg, seg_model(8'h32, edges));
    chk("acc_seg_5b", seg, 7'h5B);
    // Overflow: 9x30 then 10
    do_clear();
    for (int i = 0; i < 9; i++) send(5'd30);
    chk("ovf_acc9", acc_out, 14);
    chk("ovf_flag9", ovf, 1);
    send(5'd10);
    chk("ovf_acc10", acc_out, 24);
    chk("ovf_sticky", ovf, 1);
    chk("ovf_count", count, 10);
    // 30 against 250
    do_clear();
    chk("clr_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) send(5'd30);
    send(5'd10);
    chk("b250_acc", acc_out, 250);
    chk("b250_ovf", ovf, 0);
    send(5'd30);
    chk("b250_wrap", acc_out, 24);
    chk("b250_ovf1", ovf, 1);
    // Saturation with valid held high
    do_clear();
    sum_in = 5'd1;
    sum_valid = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat14_count", count, 14);
    chk("sat14_done", done, 0);
    chk("sat14_ready", sum_ready, 1);
    tick();
    chk("sat_done", done, 1);
    chk("sat_ready", sum_ready, 0);
    chk("sat_acc", acc_out, 15);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_hold_acc", acc_out, 15);
    chk("sat_hold_count", count, 15);
    chk("sat_hold_done", done, 1);
    // Clear in FULL with valid still high
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sum_valid = 1'b0;
    chk("fclr_ready", sum_ready, 1);
    chk("fclr_done", done, 0);
    chk("fclr_acc", acc_out, 0);
    chk("fclr_count", count, 0);
    // Clear beats a same-edge transfer
    send(5'd10);
    send(5'd10);
    chk("pri_pre", acc_out, 20);
    sum_in = 5'h07;
    sum_valid = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sum_valid = 1'b0;
    chk("pri_acc", acc_out, 0);
    chk("pri_count", count, 0);
    tick();
    chk("pri_dropped", acc_out, 0);
    send(5'h07);
    chk("pri_after_acc", acc_out, 7);
    chk("pri_after_count", count, 1);
    // Display mux on 0xA3
    do_clear();
    for (int i = 0; i < 5; i++) send(5'd30);
    send(5'd13);
    chk("disp_acc", acc_out, 8'hA3);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("disp_dig", dig_sel, dig_at(edges));
      chk("disp_seg", seg, seg_model(8'hA3, edges));
      chk("disp_seg_code", seg, dig_at(edges - 1) ? 7'h77 : 7'h4F);
    end
    // Reset in the middle of accumulation
    send(5'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_dig", dig_sel, 0);
    chk("mid_rst_seg", seg, 7'h3F);
    @(negedge clk);
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
